// File: rtl/csoc_test_pkg.sv
// Shared opcodes, response codes and controller state encoding for the
// CSoC test command sequencer.
package csoc_test_pkg;

    localparam logic [7:0] OP_RESET = 8'h01;
    localparam logic [7:0] OP_MODE  = 8'h02;
    localparam logic [7:0] OP_WRITE = 8'h03;
    localparam logic [7:0] OP_READ  = 8'h04;
    localparam logic [7:0] OP_STEP  = 8'h05;
    localparam logic [7:0] OP_RUN   = 8'h06;
    localparam logic [7:0] OP_STOP  = 8'h07;

    localparam logic [7:0] RSP_ERR      = 8'hEE;
    localparam logic [7:0] RSP_ACK_BASE = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } ctrl_state_e;

    // Opcodes in 0x01..0x07 are the only ones the sequencer understands.
    function automatic logic op_is_known(input logic [7:0] op);
        return (op >= OP_RESET) && (op <= OP_STOP);
    endfunction

    // READ and STOP are single-byte commands; every other known opcode
    // is followed by one argument byte.
    function automatic logic op_has_arg(input logic [7:0] op);
        return (op == OP_RESET) || (op == OP_MODE) || (op == OP_WRITE) ||
               (op == OP_STEP)  || (op == OP_RUN);
    endfunction

    function automatic logic [7:0] ack_code(input logic [7:0] op);
        return RSP_ACK_BASE | op;
    endfunction

endpackage

// File: rtl/csoc_test_ctrl_if.sv
// Host-side byte channel between the UART cores and the test sequencer.
//
// Handshake semantics:
//   rx: rx_valid is a single-cycle strobe with no back-pressure; rx_data is
//       only meaningful in that cycle and the receiver must take it or drop it.
//   tx: a response byte transfers in a cycle where tx_valid && tx_ready.
//       Once tx_valid rises, tx_valid and tx_data stay stable until that
//       transfer cycle; tx_ready may toggle freely and never depends on
//       tx_valid.
interface csoc_test_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // UART side: supplies received bytes, consumes responses.
    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    // Sequencer side.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/csoc_clk_gen.sv
// CSoC clock generator: divides clk by 2*CLK_DIV, gated by run/force/step,
// and reports the cycles in which csoc_clk is about to rise or fall.
module csoc_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_i,
    input  logic       force_i,
    input  logic       step_load_i,
    input  logic [7:0] step_val_i,
    output logic       csoc_clk_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic [7:0] step_cnt_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic             clk_q;
    logic [7:0]       step_cnt_q;
    logic             enable;
    logic             wrap;

    // Keep toggling while the clock is high so a stop always parks it at 0
    // after a complete high phase.
    always_comb begin
        enable = run_i | force_i | (step_cnt_q != 8'd0) | clk_q;
        wrap   = (div_q == DIV_W'(CLK_DIV - 1));
        rise_o = enable & wrap & ~clk_q;
        fall_o = enable & wrap & clk_q;
    end

    // Divider, output clock and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            clk_q      <= 1'b0;
            step_cnt_q <= 8'd0;
        end else begin
            if (enable) begin
                if (wrap) begin
                    div_q <= '0;
                    clk_q <= ~clk_q;
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end else begin
                div_q <= '0;
            end

            if (step_load_i) begin
                step_cnt_q <= step_val_i;
            end else if (rise_o && (step_cnt_q != 8'd0)) begin
                step_cnt_q <= step_cnt_q - 8'd1;
            end
        end
    end

    assign csoc_clk_o = clk_q;
    assign step_cnt_o = step_cnt_q;

endmodule

// File: rtl/csoc_test_ctrl.sv
// Command sequencer: decodes host opcode/argument pairs, drives the CSoC
// test pins and returns exactly one response byte per command.
module csoc_test_ctrl
    import csoc_test_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int RD_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    csoc_test_ctrl_if.slave   host,
    output logic              busy,
    output logic              csoc_clk,
    output logic              csoc_rstn,
    output logic              csoc_test_se,
    output logic              csoc_test_tm,
    output logic              csoc_uart_write,
    output logic [7:0]        csoc_data_i,
    input  logic              csoc_uart_read,
    input  logic [7:0]        csoc_data_o,
    output ctrl_state_e       state_o
);

    // Shared by the RESET hold count and the READ timeout count.
    localparam int CNT_W = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;

    ctrl_state_e      state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             rstn_q, rstn_d;
    logic             tm_q, tm_d;
    logic             se_q, se_d;
    logic             wr_q, wr_d;
    logic [7:0]       data_q, data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;

    logic             step_load;
    logic [7:0]       step_val;
    logic             force_clk;
    logic             done;
    logic [7:0]       rsp;

    logic             gen_clk;
    logic             gen_rise;
    logic             gen_fall;
    logic [7:0]       gen_step_cnt;

    csoc_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .run_i       (run_q),
        .force_i     (force_clk),
        .step_load_i (step_load),
        .step_val_i  (step_val),
        .csoc_clk_o  (gen_clk),
        .rise_o      (gen_rise),
        .fall_o      (gen_fall),
        .step_cnt_o  (gen_step_cnt)
    );

    // Next-state and command sequencing; 'done' funnels every command into RESP.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        rstn_d     = rstn_q;
        tm_d       = tm_q;
        se_d       = se_q;
        wr_d       = wr_q;
        data_d     = data_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        step_load  = 1'b0;
        step_val   = 8'd0;
        force_clk  = 1'b0;
        done       = 1'b0;
        rsp        = RSP_ERR;

        case (state_q)
            ST_IDLE: begin
                if (host.rx_valid) begin
                    opcode_d = host.rx_data;
                    cnt_d    = '0;
                    if (!op_is_known(host.rx_data)) begin
                        done = 1'b1;
                        rsp  = RSP_ERR;
                    end else if (op_has_arg(host.rx_data)) begin
                        state_d = ST_ARG;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_ARG: begin
                // Argument side effects land on the ARG->EXEC transition so
                // they are visible the cycle after the argument byte.
                if (host.rx_valid) begin
                    state_d = ST_EXEC;
                    case (opcode_q)
                        OP_RESET: begin
                            rstn_d = 1'b0;
                            cnt_d  = (host.rx_data == 8'd0) ? CNT_W'(1) : CNT_W'(host.rx_data);
                        end
                        OP_MODE: begin
                            tm_d = host.rx_data[0];
                            se_d = host.rx_data[1];
                        end
                        OP_WRITE: begin
                            data_d = host.rx_data;
                            wr_d   = 1'b1;
                        end
                        OP_STEP: begin
                            step_load = 1'b1;
                            step_val  = host.rx_data;
                        end
                        default: ;
                    endcase
                end
            end

            ST_EXEC: begin
                case (opcode_q)
                    OP_RESET: begin
                        // Count the hold on rising edges, release on the
                        // following falling edge so rstn never moves
                        // together with a rising csoc_clk.
                        force_clk = 1'b1;
                        if (gen_rise && (cnt_q != '0)) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else if (gen_fall && (cnt_q == '0)) begin
                            rstn_d = 1'b1;
                            done   = 1'b1;
                            rsp    = ack_code(opcode_q);
                        end
                    end
                    OP_MODE: begin
                        done = 1'b1;
                        rsp  = ack_code(opcode_q);
                    end
                    OP_WRITE: begin
                        force_clk = 1'b1;
                        if (gen_rise) begin
                            wr_d = 1'b0;
                            done = 1'b1;
                            rsp  = ack_code(opcode_q);
                        end
                    end
                    OP_READ: begin
                        force_clk = 1'b1;
                        if (gen_rise) begin
                            if (csoc_uart_read) begin
                                done = 1'b1;
                                rsp  = csoc_data_o;
                            end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                                done = 1'b1;
                                rsp  = RSP_ERR;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    OP_STEP: begin
                        if (gen_step_cnt == 8'd0) begin
                            done = 1'b1;
                            rsp  = ack_code(opcode_q);
                        end
                    end
                    OP_RUN: begin
                        run_d = 1'b1;
                        done  = 1'b1;
                        rsp   = ack_code(opcode_q);
                    end
                    OP_STOP: begin
                        run_d = 1'b0;
                        done  = 1'b1;
                        rsp   = ack_code(opcode_q);
                    end
                    default: begin
                        done = 1'b1;
                        rsp  = RSP_ERR;
                    end
                endcase
            end

            ST_RESP: begin
                if (host.tx_ready) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            state_d    = ST_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = rsp;
        end
    end

    // State and datapath registers; reset aborts any command silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            opcode_q   <= 8'd0;
            cnt_q      <= '0;
            run_q      <= 1'b0;
            rstn_q     <= 1'b0;
            tm_q       <= 1'b0;
            se_q       <= 1'b0;
            wr_q       <= 1'b0;
            data_q     <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            rstn_q     <= rstn_d;
            tm_q       <= tm_d;
            se_q       <= se_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign host.tx_valid   = tx_valid_q;
    assign host.tx_data    = tx_data_q;
    assign busy            = (state_q != ST_IDLE);
    assign csoc_clk        = gen_clk;
    assign csoc_rstn       = rstn_q;
    assign csoc_test_tm    = tm_q;
    assign csoc_test_se    = se_q;
    assign csoc_uart_write = wr_q;
    assign csoc_data_i     = data_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_csoc_test_ctrl.sv
// Self-checking bench for csoc_test_ctrl.
module tb_csoc_test_ctrl;
    import csoc_test_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int RD_TIMEOUT = 1024;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic        csoc_clk;
    logic        csoc_rstn;
    logic        csoc_test_se;
    logic        csoc_test_tm;
    logic        csoc_uart_write;
    logic [7:0]  csoc_data_i;
    logic        csoc_uart_read = 1'b0;
    logic [7:0]  csoc_data_o = 8'h00;
    ctrl_state_e state_o;

    csoc_test_ctrl_if host_if ();

    csoc_test_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .host            (host_if),
        .busy            (busy),
        .csoc_clk        (csoc_clk),
        .csoc_rstn       (csoc_rstn),
        .csoc_test_se    (csoc_test_se),
        .csoc_test_tm    (csoc_test_tm),
        .csoc_uart_write (csoc_uart_write),
        .csoc_data_i     (csoc_data_i),
        .csoc_uart_read  (csoc_uart_read),
        .csoc_data_o     (csoc_data_o),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / monitor ----------------
    int tests = 0;
    int fails = 0;
    int rise_cnt = 0;
    int rstn_low_rises = 0;
    int wr_rises = 0;
    int tx_count = 0;
    logic prev_clk = 1'b0;
    logic prev_rstn = 1'b0;
    logic prev_wr = 1'b0;
    logic [7:0] rsp_q[$];
    logic [7:0] exp_q[$];

    // Observe the pins mid-cycle; "prev" values are what the CSoC samples
    // at a rising csoc_clk.
    always @(negedge clk) begin
        if (csoc_clk && !prev_clk) begin
            rise_cnt++;
            if (!prev_rstn) rstn_low_rises++;
            if (prev_wr) wr_rises++;
        end
        prev_clk  = csoc_clk;
        prev_rstn = csoc_rstn;
        prev_wr   = csoc_uart_write;
        if (host_if.tx_valid && host_if.tx_ready) begin
            tx_count++;
            rsp_q.push_back(host_if.tx_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        host_if.rx_data  = b;
        host_if.rx_valid = 1'b1;
        tick();
        host_if.rx_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        logic [7:0] got;
        logic [7:0] exp;
        for (int i = 0; i < budget; i++) begin
            if (rsp_q.size() > 0) break;
            tick();
        end
        chk({tag, "_arrived"}, 32'(rsp_q.size() > 0), 32'd1);
        if (rsp_q.size() > 0 && exp_q.size() > 0) begin
            got = rsp_q.pop_front();
            exp = exp_q.pop_front();
            chk({tag, "_rsp"}, 32'(got), 32'(exp));
        end
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] op, input logic [7:0] arg,
                          input logic has_arg, input logic [7:0] exp);
        exp_q.push_back(exp);
        send_byte(op);
        if (has_arg) send_byte(arg);
        wait_rsp(tag, 20000);
    endtask

    task automatic wait_rise(output int n);
        int r0;
        r0 = rise_cnt;
        n  = 0;
        while (rise_cnt == r0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Reference rule: known opcodes acknowledge with 0xA0|op, others 0xEE.
    function automatic logic [7:0] exp_ack(input logic [7:0] op);
        return (op >= 8'd1 && op <= 8'd7) ? (8'hA0 | op) : 8'hEE;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        int r0;
        int lowc;
        int unstable;
        int tx0;
        logic exp_tm;
        logic exp_se;
        logic [7:0] exp_data;
        logic [7:0] a;
        logic [7:0] op;

        host_if.rx_data  = 8'h00;
        host_if.rx_valid = 1'b0;
        host_if.tx_ready = 1'b1;
        exp_tm   = 1'b0;
        exp_se   = 1'b0;
        exp_data = 8'h00;

        repeat (4) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_csoc_clk", 32'(csoc_clk), 32'd0);
        chk("rst_rstn", 32'(csoc_rstn), 32'd0);
        chk("rst_tm_se", {30'd0, csoc_test_se, csoc_test_tm}, 32'd0);
        chk("rst_uart_write", 32'(csoc_uart_write), 32'd0);
        chk("rst_data_i", 32'(csoc_data_i), 32'd0);
        chk("rst_tx", {host_if.tx_valid, 15'd0, 8'd0, host_if.tx_data}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(state_o), 32'(ST_IDLE));

        // MODE 0x03: effective next cycle, response two cycles after arg
        exp_q.push_back(exp_ack(OP_MODE));
        send_byte(OP_MODE);
        send_byte(8'h03);
        exp_tm = 1'b1;
        exp_se = 1'b1;
        chk("mode_tm", 32'(csoc_test_tm), 32'(exp_tm));
        chk("mode_se", 32'(csoc_test_se), 32'(exp_se));
        chk("mode_txv_early", 32'(host_if.tx_valid), 32'd0);
        chk("mode_busy", 32'(busy), 32'd1);
        tick();
        chk("mode_txv_lat2", 32'(host_if.tx_valid), 32'd1);
        wait_rsp("mode", 50);
        chk("mode_rstn_held", 32'(csoc_rstn), 32'd0);
        chk("mode_no_clk", 32'(rise_cnt), 32'd0);

        // RESET 4: 4 rising edges with rstn low, 2*CLK_DIV*4 cycles low
        rstn_low_rises = 0;
        exp_q.push_back(exp_ack(OP_RESET));
        send_byte(OP_RESET);
        send_byte(8'h04);
        lowc = 0;
        while (csoc_rstn == 1'b0 && lowc < 500) begin
            lowc++;
            tick();
        end
        chk("reset_low_cycles", 32'(lowc), 32'(2 * CLK_DIV * 4));
        wait_rsp("reset", 100);
        chk("reset_low_rises", 32'(rstn_low_rises), 32'd4);
        chk("reset_rstn_high", 32'(csoc_rstn), 32'd1);

        // WRITE 0x5A: strobe spans exactly one rising edge
        wr_rises = 0;
        exp_q.push_back(exp_ack(OP_WRITE));
        send_byte(OP_WRITE);
        send_byte(8'h5A);
        exp_data = 8'h5A;
        chk("write_data_i", 32'(csoc_data_i), 32'(exp_data));
        chk("write_strobe_on", 32'(csoc_uart_write), 32'd1);
        wait_rsp("write", 100);
        repeat (10) tick();
        chk("write_one_edge", 32'(wr_rises), 32'd1);
        chk("write_strobe_off", 32'(csoc_uart_write), 32'd0);

        // READ with data after 10 edges
        r0 = rise_cnt;
        exp_q.push_back(8'hC3);
        send_byte(OP_READ);
        n = 0;
        while ((rise_cnt - r0) < 10 && n < 500) begin
            tick();
            n++;
        end
        csoc_data_o    = 8'hC3;
        csoc_uart_read = 1'b1;
        wait_rsp("read_data", 200);
        csoc_uart_read = 1'b0;

        // READ timeout
        repeat (20) tick();
        r0 = rise_cnt;
        exp_q.push_back(RSP_ERR);
        send_byte(OP_READ);
        wait_rsp("read_timeout", 20000);
        chk("read_timeout_edges", 32'(rise_cnt - r0), 32'(RD_TIMEOUT));

        // STEP 5 with run=0
        repeat (20) tick();
        r0 = rise_cnt;
        do_cmd("step5", OP_STEP, 8'd5, 1'b1, exp_ack(OP_STEP));
        repeat (40) tick();
        chk("step5_edges", 32'(rise_cnt - r0), 32'd5);
        chk("step5_parked", 32'(csoc_clk), 32'd0);

        // RUN: free-running period of 2*CLK_DIV
        do_cmd("run", OP_RUN, 8'h00, 1'b1, exp_ack(OP_RUN));
        wait_rise(n);
        wait_rise(n);
        chk("run_period_a", 32'(n), 32'(2 * CLK_DIV));
        wait_rise(n);
        chk("run_period_b", 32'(n), 32'(2 * CLK_DIV));

        // STOP: clock parks low
        do_cmd("stop", OP_STOP, 8'h00, 1'b0, exp_ack(OP_STOP));
        repeat (20) tick();
        r0 = rise_cnt;
        repeat (30) tick();
        chk("stop_no_edges", 32'(rise_cnt - r0), 32'd0);
        chk("stop_parked", 32'(csoc_clk), 32'd0);

        // Randomized commands against the reference rules
        for (int k = 0; k < 40; k++) begin
            a = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0: begin
                    do_cmd("rnd_mode", OP_MODE, a, 1'b1, exp_ack(OP_MODE));
                    exp_tm = a[0];
                    exp_se = a[1];
                    chk("rnd_tm", 32'(csoc_test_tm), 32'(exp_tm));
                    chk("rnd_se", 32'(csoc_test_se), 32'(exp_se));
                end
                1: begin
                    do_cmd("rnd_write", OP_WRITE, a, 1'b1, exp_ack(OP_WRITE));
                    exp_data = a;
                    chk("rnd_data_i", 32'(csoc_data_i), 32'(exp_data));
                end
                2: begin
                    op = 8'($urandom_range(8, 255));
                    do_cmd("rnd_badop", op, 8'h00, 1'b0, exp_ack(op));
                end
                3: do_cmd("rnd_run", OP_RUN, a, 1'b1, exp_ack(OP_RUN));
                4: do_cmd("rnd_stop", OP_STOP, 8'h00, 1'b0, exp_ack(OP_STOP));
                5: do_cmd("rnd_step", OP_STEP, 8'($urandom_range(0, 3)), 1'b1, exp_ack(OP_STEP));
                6: begin
                    do_cmd("rnd_reset", OP_RESET, 8'($urandom_range(0, 2)), 1'b1, exp_ack(OP_RESET));
                    chk("rnd_rstn", 32'(csoc_rstn), 32'd1);
                end
                default: begin
                    csoc_data_o    = a;
                    csoc_uart_read = 1'b1;
                    do_cmd("rnd_read", OP_READ, 8'h00, 1'b0, a);
                    csoc_uart_read = 1'b0;
                end
            endcase
        end
        chk("rnd_uart_write_idle", 32'(csoc_uart_write), 32'd0);

        // Bad opcode with back-pressure; bytes during RESP are dropped
        host_if.tx_ready = 1'b0;
        tx0 = tx_count;
        exp_q.push_back(RSP_ERR);
        send_byte(8'h99);
        chk("bad_txv_lat1", 32'(host_if.tx_valid), 32'd1);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                host_if.rx_data  = OP_MODE;
                host_if.rx_valid = 1'b1;
            end else if (i == 6) begin
                host_if.rx_data  = {6'd0, ~exp_se, ~exp_tm};
            end else if (i == 7) begin
                host_if.rx_valid = 1'b0;
            end
            if (!(host_if.tx_valid === 1'b1 && host_if.tx_data === RSP_ERR)) unstable++;
            tick();
        end
        chk("bad_hold_stable", 32'(unstable), 32'd0);
        chk("bad_not_sent_yet", 32'(tx_count - tx0), 32'd0);
        host_if.tx_ready = 1'b1;
        wait_rsp("bad_op", 50);
        repeat (30) tick();
        chk("bad_sent_once", 32'(tx_count - tx0), 32'd1);
        chk("drop_tm", 32'(csoc_test_tm), 32'(exp_tm));
        chk("drop_se", 32'(csoc_test_se), 32'(exp_se));
        chk("drop_idle", 32'(busy), 32'd0);

        // Reset during a RESET hold: no response, reset values restored
        tx0 = tx_count;
        send_byte(OP_RESET);
        send_byte(8'h10);
        repeat (20) tick();
        chk("midrst_rstn_low", 32'(csoc_rstn), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("midrst_csoc_clk", 32'(csoc_clk), 32'd0);
        chk("midrst_rstn", 32'(csoc_rstn), 32'd0);
        chk("midrst_tm_se", {30'd0, csoc_test_se, csoc_test_tm}, 32'd0);
        chk("midrst_write", {23'd0, csoc_uart_write, csoc_data_i}, 32'd0);
        chk("midrst_tx", {host_if.tx_valid, 15'd0, 8'd0, host_if.tx_data}, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        r0 = rise_cnt;
        repeat (100) tick();
        chk("midrst_no_rsp", 32'(tx_count - tx0), 32'd0);
        chk("midrst_clk_stopped", 32'(rise_cnt - r0), 32'd0);
        chk("midrst_exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
